sr_reg_bank: RTL
================

// Module: sr_reg_bank
// PURPOSE
//   Parametrised bank of WIDTH independent set/reset flags with per-channel enable.
//   Conflict resolution (S=R=1) is selectable: hold, set-dominant, reset-dominant or toggle.
//   Provides registered rise/fall pulses and sticky per-channel conflict flags.
//   Sits between status-event sources and control/interrupt logic.
// PARAMETERS
//   WIDTH          8     number of channels (1..64)
//   CONFLICT_MODE  1     S=R=1 action: 0=hold, 1=set-dominant, 2=reset-dominant, 3=toggle
//   RESET_VAL      0     WIDTH-bit value loaded into q on reset
//   CNT_W          8     conflict counter width (used only with SR_CONFLICT_CNT_EN)
// PORTS
//   clk            in   1           rising-edge clock
//   reset          in   1           synchronous, active-high reset
//   en             in   WIDTH       per-channel update enable; 0 = channel holds
//   s              in   WIDTH       per-channel set request
//   r              in   WIDTH       per-channel reset request
//   conflict_clr   in   1           clears all sticky conflict flags (and counter)
//   q              out  WIDTH       registered flag state
//   q_rise         out  WIDTH       1-cycle pulse: q[i] went 0->1 on this edge
//   q_fall         out  WIDTH       1-cycle pulse: q[i] went 1->0 on this edge
//   conflict       out  WIDTH       sticky: channel saw en&s&r=1 since last clear
//   conflict_any   out  1           OR-reduction of conflict (registered value, no extra delay)
//   conflict_cnt   out  CNT_W       saturating conflict count (SR_CONFLICT_CNT_EN only)
// BEHAVIOUR
//   - One clock, one reset; reset is synchronous and active-high. Port names: clk, reset.
//   - Reset: q=RESET_VAL, q_rise=0, q_fall=0, conflict=0, conflict_any=0, conflict_cnt=0.
//     Reset overrides every other input in the same cycle.
//   - Per channel i, evaluated at each rising clk edge when en[i]=1:
//       s=0 r=0 -> hold; s=0 r=1 -> 0; s=1 r=0 -> 1;
//       s=1 r=1 -> per CONFLICT_MODE (hold / 1 / 0 / ~q[i]).
//     en[i]=0 -> q[i] holds; s/r ignored; no conflict recorded.
//   - Latency: q reflects inputs one cycle after they are sampled. No X is ever driven.
//   - q_rise[i]/q_fall[i]: registered alongside q. Asserted for exactly the cycle in which the
//     new q value is first visible. Never both 1. Deasserted after a non-changing edge.
//     Toggle mode with a held conflict gives alternating rise/fall pulses every cycle.
//   - conflict[i]: set on an edge where en[i]&s[i]&r[i]=1 (all modes, including hold).
//     Cleared by conflict_clr. Simultaneous clr and new conflict -> flag ends 1 (set wins).
//   - conflict_any = |conflict (combinational from registered flags).
//   - Channels are fully independent; no cross-channel priority.
//   - Illegal parameter (CONFLICT_MODE>3, WIDTH<1) -> elaboration error via generate check.
// CONFIGURATION
//   SR_CONFLICT_CNT_EN defined:
//     conflict_cnt port present. Each edge adds popcount(en&s&r) and saturates at 2^CNT_W-1
//     (never wraps). conflict_clr zeroes it. Simultaneous clr and new conflicts -> loads
//     that cycle's popcount.
//   SR_CONFLICT_CNT_EN not defined:
//     conflict_cnt port and counter logic absent. All other behaviour identical.
// TESTING
//   1 reset=1 for 2 cycles, RESET_VAL=8'hA5 -> q=8'hA5; rise/fall/conflict=0; cnt=0.
//   2 en=FF, s=8'h0F, r=0 from q=0 -> next cycle q=8'h0F, q_rise=8'h0F; cycle after, q_rise=0.
//   3 MODE=1/2/3, en[0]=1, s[0]=r[0]=1, q[0]=0 -> q[0]=1/0/1 respectively.
//     MODE 3 held for 3 cycles -> q[0] 1,0,1 with rise,fall,rise pulses. conflict[0]=1.
//   4 en=0, s=FF, r=FF -> q unchanged; conflict unchanged; cnt unchanged.
//   5 conflict_clr=1 with en[3]&s[3]&r[3]=1 in the same cycle -> conflict=8'h08; cnt=1 (with macro).
//   6 CNT_W=2 with macro; 4 channels in conflict for 1 cycle -> cnt=3 (saturated).
//     Assert reset mid-sequence -> all outputs return to reset values next edge.

Source files
------------

// File: rtl/sr_reg_bank.sv
// Bank of WIDTH independent set/reset flags with selectable S=R=1 resolution,
// registered rise/fall pulses and sticky conflict flags. Optional counter: SR_CONFLICT_CNT_EN.
module sr_reg_bank #(
    parameter int               WIDTH         = 8,
    parameter int               CONFLICT_MODE = 1,
    parameter logic [WIDTH-1:0] RESET_VAL     = '0,
    parameter int               CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] en,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    input  logic             conflict_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_rise,
    output logic [WIDTH-1:0] q_fall,
    output logic [WIDTH-1:0] conflict,
    output logic             conflict_any
`ifdef SR_CONFLICT_CNT_EN
    ,
    output logic [CNT_W-1:0] conflict_cnt
`endif
);

    if (WIDTH < 1 || WIDTH > 64 || CONFLICT_MODE < 0 || CONFLICT_MODE > 3 || CNT_W < 1)
    begin : g_param_check
        $error("sr_reg_bank: illegal parameter value");
    end

    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] hit;

    assign hit = en & s & r;

    always_comb begin
        q_nxt = q;
        for (int i = 0; i < WIDTH; i++) begin
            if (en[i]) begin
                unique case ({s[i], r[i]})
                    2'b10:   q_nxt[i] = 1'b1;
                    2'b01:   q_nxt[i] = 1'b0;
                    2'b11: begin
                        case (CONFLICT_MODE)
                            1:       q_nxt[i] = 1'b1;
                            2:       q_nxt[i] = 1'b0;
                            3:       q_nxt[i] = ~q[i];
                            default: q_nxt[i] = q[i];
                        endcase
                    end
                    default: q_nxt[i] = q[i];
                endcase
            end
        end
    end

    // Edge pulses are derived from the same next-state so they align with the new q.
    always_ff @(posedge clk) begin
        if (reset) begin
            q        <= RESET_VAL;
            q_rise   <= '0;
            q_fall   <= '0;
            conflict <= '0;
        end else begin
            q        <= q_nxt;
            q_rise   <= q_nxt & ~q;
            q_fall   <= ~q_nxt & q;
            conflict <= (conflict_clr ? '0 : conflict) | hit;
        end
    end

    assign conflict_any = |conflict;

`ifdef SR_CONFLICT_CNT_EN
    localparam int PC_W  = $clog2(WIDTH + 1);
    localparam int SUM_W = CNT_W + PC_W + 1;

    function automatic logic [PC_W-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [PC_W-1:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            c = c + PC_W'(v[i]);
        end
        return c;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [PC_W-1:0]  b);
        logic [SUM_W-1:0] sum;
        logic [SUM_W-1:0] max_val;
        sum     = SUM_W'(a) + SUM_W'(b);
        max_val = SUM_W'({CNT_W{1'b1}});
        return (sum > max_val) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    // A clear in the same cycle as new conflicts restarts from zero, keeping this cycle's hits.
    always_ff @(posedge clk) begin
        if (reset) begin
            conflict_cnt <= '0;
        end else begin
            conflict_cnt <= sat_add(conflict_clr ? '0 : conflict_cnt, popcount(hit));
        end
    end
`endif

endmodule
